// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin grant, locked for the
// whole owner bus cycle, with a per-transfer watchdog that turns a missing ack into err.
module wb_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

    localparam bit                   WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TLAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;

    logic own_cyc, own_stb;
    assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

    // Read data is broadcast; masters only take it when they see their own ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tcnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = BUSY;
                    owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (own_stb && !s_ack_i) begin
                    // An ack arriving on the last allowed cycle takes this branch's else.
                    if (WD_EN && tcnt_q == TLAST) begin
                        state_d = ERR;
                    end
                    tcnt_d = WD_EN ? tcnt_q + 1'b1 : '0;
                end
            end
            ERR: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        grant_o  = 2'b00;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            BUSY: begin
                s_adr_o  = owner_q ? m1_adr_i : m0_adr_i;
                s_dat_o  = owner_q ? m1_dat_i : m0_dat_i;
                s_we_o   = owner_q ? m1_we_i  : m0_we_i;
                s_stb_o  = own_stb;
                s_cyc_o  = own_cyc;
                grant_o  = owner_q ? 2'b10 : 2'b01;
                m0_ack_o = s_ack_i & ~owner_q & m0_stb_i;
                m1_ack_o = s_ack_i &  owner_q & m1_stb_i;
            end
            ERR: begin
                grant_o  = owner_q ? 2'b10 : 2'b01;
                m0_err_o = ~owner_q;
                m1_err_o =  owner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: arbitration table, scoreboarded slave transfers, watchdog
// and asynchronous-reset corner cases against a small behavioural slave.
module tb_wb_arbiter2;

    localparam int W = 65;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [31:0] m_adr[2];
    logic [31:0] m_wdat[2];
    wire  [31:0] m0_dat, m1_dat;
    wire  [1:0]  m_ack, m_err;
    wire  [31:0] s_adr_o, s_dat_o;
    wire         s_we_o, s_stb_o, s_cyc_o;
    wire  [1:0]  grant_o;
    logic [31:0] rd_val = '0;
    logic        s_ack_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_m   = 0;
    int slv_mode = 0;  // 0: registered 1-cycle ack, 1: never ack, 2: ack on 4th stb cycle
    logic [W-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]),
        .m0_cyc_i(m_cyc[0]), .m0_dat_o(m0_dat), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]),
        .m1_cyc_i(m_cyc[1]), .m1_dat_o(m1_dat), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o), .s_dat_i(rd_val), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    // Behavioural slave
    logic       ack_q;
    logic [2:0] stb_cnt;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            stb_cnt <= '0;
        end else begin
            ack_q   <= (slv_mode == 0) && s_cyc_o && s_stb_o && !ack_q;
            stb_cnt <= (s_stb_o && !s_ack_i) ? stb_cnt + 3'd1 : 3'd0;
        end
    end
    assign s_ack_i = (slv_mode == 0) ? ack_q :
                     (slv_mode == 2) ? (s_stb_o && stb_cnt == 3'd3) : 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed slave beat must match the oldest expected transfer
    logic [W-1:0] mon_got;
    always @(negedge clk_i) begin
        if (!rst_i && s_cyc_o && s_stb_o && s_ack_i) begin
            mon_got = {s_we_o, s_adr_o, s_we_o ? s_dat_o : (cur_m == 1 ? m1_dat : m0_dat)};
            if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
            else chk("sb_xfer", mon_got, exp_q.pop_front());
            chk("ack_route", m_ack, cur_m == 1 ? 2'b10 : 2'b01);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic beat(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic hold);
        int n;
        cur_m = m;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_adr[m] = adr; m_wdat[m] = dat;
        exp_q.push_back({we, adr, we ? dat : rd_val});
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!m_ack[m] && n < 20);
        chk("beat_ack", m_ack[m], 1);
        tick();
        m_stb[m] = 1'b0;
        if (!hold) m_cyc[m] = 1'b0;
    endtask

    // Slow slave read: count stb cycles until ack, watching for a spurious err
    task automatic slow_read(input logic [31:0] adr, input logic [31:0] dat);
        int ns, n;
        logic err_seen;
        cur_m = 0; rd_val = dat;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = adr;
        exp_q.push_back({1'b0, adr, dat});
        ns = 0; n = 0; err_seen = 1'b0;
        do begin
            @(negedge clk_i);
            n++;
            if (s_stb_o) ns++;
            if (m_err != 2'b00) err_seen = 1'b1;
        end while (!m_ack[0] && n < 12);
        chk("slow_stb_cycles", ns, 4);
        chk("slow_no_err", err_seen, 0);
        tick();
        m_stb[0] = 1'b0;
    endtask

    typedef struct {
        logic       c0;
        logic       c1;
        logic [1:0] g;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int ns, n;
        m_adr[0] = '0; m_adr[1] = '0; m_wdat[0] = '0; m_wdat[1] = '0;
        // Tie-break sequence starting from reset (last_owner = 1)
        tbl[0] = '{1'b1, 1'b1, 2'b01};
        tbl[1] = '{1'b1, 1'b1, 2'b10};
        tbl[2] = '{1'b0, 1'b1, 2'b10};
        tbl[3] = '{1'b1, 1'b1, 2'b01};
        tbl[4] = '{1'b1, 1'b0, 2'b01};
        tbl[5] = '{1'b1, 1'b1, 2'b10};

        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        chk("rst_sadr", s_adr_o, 0);
        chk("rst_ackerr", {m_ack, m_err}, 4'b0000);
        tick(); tick();
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            tick();
            m_cyc = {tbl[i].c1, tbl[i].c0};
            @(negedge clk_i);
            chk("tbl_idle_grant", grant_o, 2'b00);
            @(negedge clk_i);
            chk("tbl_grant", grant_o, tbl[i].g);
            chk("tbl_scyc", s_cyc_o, 1);
            tick();
            m_cyc = 2'b00;
            @(negedge clk_i);
            @(negedge clk_i);
        end

        // Single read latency
        do_reset();
        tick();
        rd_val = 32'hA5A5_0001; cur_m = 0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h8;
        exp_q.push_back({1'b0, 32'h8, 32'hA5A5_0001});
        @(negedge clk_i);
        chk("rd_t0_scyc", s_cyc_o, 0);
        @(negedge clk_i);
        chk("rd_t1_scyc", {s_cyc_o, s_stb_o}, 2'b11);
        chk("rd_t1_grant", grant_o, 2'b01);
        chk("rd_t1_ack", m_ack, 2'b00);
        @(negedge clk_i);
        chk("rd_t2_ack", m_ack, 2'b01);
        chk("rd_t2_dat", m0_dat, 32'hA5A5_0001);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick(); tick();

        // Simultaneous request after reset, then handover through one idle cycle
        do_reset();
        m_cyc = 2'b11;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("sim_first", grant_o, 2'b01);
        tick();
        m_cyc[0] = 1'b0;
        @(negedge clk_i);
        chk("sim_drop_scyc", s_cyc_o, 0);
        @(negedge clk_i);
        chk("sim_idle", grant_o, 2'b00);
        @(negedge clk_i);
        chk("sim_second", grant_o, 2'b10);
        tick();
        m_cyc = 2'b00;
        tick(); tick();
        m_cyc = 2'b11;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("sim_third", grant_o, 2'b01);
        tick();
        m_cyc = 2'b00;
        tick(); tick();

        // Locked burst of four writes while m1 keeps requesting
        do_reset();
        m_adr[1] = 32'h100; m_wdat[1] = 32'hDEAD_BEEF; m_we[1] = 1'b1;
        m_cyc[1] = 1'b1;
        for (int i = 1; i <= 4; i++) beat(0, 1'b1, 32'hC, i, 1'b1);
        m_cyc[0] = 1'b0;
        @(negedge clk_i);
        chk("lock_drop_scyc", s_cyc_o, 0);
        @(negedge clk_i);
        chk("lock_idle", grant_o, 2'b00);
        @(negedge clk_i);
        chk("lock_m1", grant_o, 2'b10);
        tick();
        m_cyc[1] = 1'b0;
        tick(); tick();

        // Watchdog: slave never acks m1
        slv_mode = 1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        ns = 0; n = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (s_stb_o) ns++;
            chk("to_m0_err", m_err[0], 0);
        end while (!m_err[1] && n < 12);
        chk("to_stb_cycles", ns, 4);
        chk("to_err", m_err, 2'b10);
        chk("to_err_scyc", {s_cyc_o, s_stb_o}, 2'b00);
        chk("to_err_ack", m_ack, 2'b00);
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk_i);
        chk("to_idle", {grant_o, m_err}, 4'b0000);
        tick();

        // Ack on the last allowed cycle beats the watchdog, twice under lock
        slv_mode = 2;
        slow_read(32'h10, 32'h5A5A_0005);
        slow_read(32'h14, 32'h5A5A_0006);
        m_cyc[0] = 1'b0;
        tick(); tick();

        // Asynchronous reset while m1 owns the bus
        slv_mode = 1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("ar_grant_pre", grant_o, 2'b10);
        #1;
        rst_i = 1'b1;
        m_cyc[0] = 1'b1;
        #1;
        chk("ar_scyc", {s_cyc_o, s_stb_o}, 2'b00);
        chk("ar_grant", grant_o, 2'b00);
        chk("ar_ackerr", {m_ack, m_err}, 4'b0000);
        tick();
        rst_i = 1'b0;
        m_stb[1] = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("ar_tie_m0", grant_o, 2'b01);
        tick();
        m_cyc = 2'b00;
        tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
